// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage: queue entry layout and
// the register-index to one-hot write-enable decode.
package wb_pkg;
    localparam int WB_DEPTH = 2;
    localparam int WB_XLEN  = 32;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // x0 has no enable bit, so rd = 0 decodes to all zeros
    function automatic logic [31:1] rd_onehot(input logic [4:0] rd);
        logic [31:0] v;
        v = 32'd1 << rd;
        return v[31:1];
    endfunction
endpackage

// File: rtl/wb_stage_if.sv
// Execute -> writeback result handshake.
interface wb_stage_if
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
);
    logic            res_valid;
    logic            res_ready;
    logic [4:0]      res_rd;
    logic [XLEN-1:0] res_data;

    modport master (output res_valid, output res_rd, output res_data, input res_ready);
    modport slave  (input res_valid, input res_rd, input res_data, output res_ready);
endinterface

// File: rtl/wb_fifo.sv
// Result queue: circular buffer with occupancy counter; push is ignored when
// full and pop is ignored when empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    parameter  int XLEN  = WB_XLEN,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic [4:0]      i_push_rd,
    input  logic [XLEN-1:0] i_push_data,
    input  logic            i_pop,
    output logic [4:0]      o_head_rd,
    output logic [XLEN-1:0] o_head_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [CW-1:0]   o_count
);
    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_rd   = r_rd[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= i_push_rd;
            r_data[r_wptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: queues execute results, issues one register-bank write per
// cycle unless held, and tracks pending destinations in a busy scoreboard.
module wb_stage
    import wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    parameter  int XLEN  = WB_XLEN,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    wb_stage_if.slave       res,
    input  logic            hold,
    input  logic            rsv_valid,
    input  logic [4:0]      rsv_rd,
    output logic [31:1]     addrw,
    output logic [XLEN-1:0] wdata,
    output logic [31:1]     busy,
    output logic [CW-1:0]   count,
    output logic            err
);
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [31:1]     w_set;
    logic [31:1]     w_clr;
    logic            w_orphan;

    logic [31:1]     r_addrw;
    logic [XLEN-1:0] r_wdata;
    logic [31:1]     r_busy;
    logic            r_err;

    assign res.res_ready = !w_full && !reset;
    assign w_push        = res.res_valid && res.res_ready;
    assign w_pop         = !hold && !w_empty && !reset;

    wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_rd   (res.res_rd),
        .i_push_data (res.res_data),
        .i_pop       (w_pop),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (count)
    );

    assign w_set    = rsv_valid ? rd_onehot(rsv_rd) : '0;
    assign w_clr    = w_pop ? rd_onehot(w_head_rd) : '0;
    // a write to a register nobody reserved means the decode/execute pairing broke
    assign w_orphan = w_pop && (w_head_rd != 5'd0) && ((r_busy & w_clr) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addrw <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_addrw <= w_clr;
            if (w_pop) r_wdata <= w_head_data;
            // set after clear: a fresh reservation outlives the write it races
            r_busy  <= (r_busy & ~w_clr) | w_set;
            if (w_orphan) r_err <= 1'b1;
        end
    end

    assign addrw = r_addrw;
    assign wdata = r_wdata;
    assign busy  = r_busy;
    assign err   = r_err;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; expected writes go to a queue checked by a
// negedge monitor, state checks are made inline.
module tb_wb_stage;
    import wb_pkg::*;

    typedef struct {
        logic [30:0] addrw;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic [31:1] addrw;
    logic [31:0] wdata;
    logic [31:1] busy;
    logic [1:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    wb_stage_if #(.XLEN(32)) rif ();

    wb_stage #(.DEPTH(2), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .res       (rif),
        .hold      (hold),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .addrw     (addrw),
        .wdata     (wdata),
        .busy      (busy),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every nonzero write enable must match the oldest expectation
    always @(negedge clk) begin
        if (addrw != '0) begin
            checks++;
            if ($countones(addrw) > 1) begin
                errors++;
                $display("FAIL onehot: addrw %0h", addrw);
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addrw %0h wdata %0h, none expected", addrw, wdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (addrw !== e.addrw || wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addrw %0h wdata %0h expected addrw %0h wdata %0h",
                             addrw, wdata, e.addrw, e.data);
                end
            end
        end
    end

    task automatic accept(input logic [30:0] ea, input logic [31:0] d, input bit expect_write);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rif.res_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            if (expect_write) q.push_back('{addrw: ea, data: d});
            tick();
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: res_ready stayed 0, expected 1");
        end
        rif.res_valid = 1'b0;
    endtask

    task automatic send(input logic [4:0] rd, input logic [31:0] d, input logic [30:0] ea,
                        input bit expect_write);
        rif.res_valid = 1'b1;
        rif.res_rd    = rd;
        rif.res_data  = d;
        accept(ea, d, expect_write);
    endtask

    task automatic reserve(input logic [4:0] rd);
        rsv_valid = 1'b1;
        rsv_rd    = rd;
        tick();
        rsv_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; rsv_valid = 1'b0; rsv_rd = '0;
        rif.res_valid = 1'b0; rif.res_rd = '0; rif.res_data = '0;
        tick();
        chk("ready_in_reset", rif.res_ready, 0);
        tick();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_addrw", addrw, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_err",   err, 0);

        // single reserved result, latency and busy clear
        reserve(5);
        chk("t1_busy_set", busy, 31'h10);
        send(5, 32'hDEADBEEF, 31'h10, 1);
        chk("t1_addrw_n", addrw, 0);
        chk("t1_count_n", count, 1);
        tick();
        chk("t1_addrw", addrw, 31'h10);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        chk("t1_busy_clr", busy, 0);
        tick();
        chk("t1_addrw_idle", addrw, 0);
        chk("t1_wdata_hold", wdata, 32'hDEADBEEF);

        // hold with full queue refuses the third result
        reserve(1); reserve(2); reserve(3);
        hold = 1'b1;
        send(1, 32'h11, 31'h1, 1);
        send(2, 32'h22, 31'h2, 1);
        rif.res_valid = 1'b1; rif.res_rd = 3; rif.res_data = 32'h33;
        #1;
        chk("t2_ready_full", rif.res_ready, 0);
        chk("t2_count_full", count, 2);
        tick();
        chk("t2_ready_full2", rif.res_ready, 0);
        chk("t2_count_full2", count, 2);
        hold = 1'b0;
        accept(31'h4, 32'h33, 1);
        tick(); tick(); tick();
        chk("t2_drained", count, 0);
        chk("t2_busy", busy, 0);
        chk("t2_err", err, 0);

        // rd = 0 never enables a write or flags an error
        send(0, 32'h1234, 31'h0, 0);
        tick(); tick();
        chk("t3_count", count, 0);
        chk("t3_err", err, 0);
        chk("t3_busy", busy, 0);

        // reservation racing the write of the same register wins
        reserve(7);
        send(7, 32'h77, 31'h40, 1);
        rsv_valid = 1'b1; rsv_rd = 7;
        tick();
        rsv_valid = 1'b0;
        chk("t4_addrw", addrw, 31'h40);
        chk("t4_busy", busy, 31'h40);
        chk("t4_err", err, 0);

        // unreserved result still writes and sets sticky err
        send(9, 32'h99, 31'h100, 1);
        tick();
        chk("t5_addrw", addrw, 31'h100);
        chk("t5_err", err, 1);
        tick(); tick();
        chk("t5_err_sticky", err, 1);

        // reset with two queued entries discards them
        hold = 1'b1;
        reserve(4);
        send(4, 32'h44, 31'h0, 0);
        send(6, 32'h66, 31'h0, 0);
        chk("t6_count", count, 2);
        reset = 1'b1;
        rif.res_valid = 1'b1; rif.res_rd = 11; rif.res_data = 32'hBB;
        rsv_valid = 1'b1; rsv_rd = 11;
        #1;
        chk("t6_ready_rst", rif.res_ready, 0);
        tick();
        reset = 1'b0; hold = 1'b0; rif.res_valid = 1'b0; rsv_valid = 1'b0;
        chk("t6_count0", count, 0);
        chk("t6_busy0", busy, 0);
        chk("t6_addrw0", addrw, 0);
        chk("t6_err0", err, 0);
        chk("t6_wdata0", wdata, 0);
        tick(); tick(); tick(); tick();
        chk("t6_count_after", count, 0);

        chk("scoreboard_empty", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
